// File: rtl/imemory_fetch.sv
// Halfword-banked instruction memory with a valid/ready fetch port, a stall-hold
// register, flush and a halfword program-load port. Returns {hw[a+1], hw[a]}.
module imemory_fetch #(
    parameter int AW = 10,
    localparam int BANK_DEPTH = 2**(AW-1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic [AW-1:0] resp_addr,
    output logic          resp_rvc,
    input  logic          flush,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    output logic [1:0]    dbg_state
);

    // Handshake: a request transfers on a cycle where req_valid && req_ready; a
    // response transfers on a cycle where resp_valid && resp_ready. Neither
    // valid depends on its own ready.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PEND  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   bank0 [BANK_DEPTH];
    logic [15:0]   bank1 [BANK_DEPTH];
    logic [15:0]   rd0;
    logic [15:0]   rd1;
    logic          odd_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   hold_data;
    logic [AW-1:0] hold_addr;
    logic          hold_rvc;
    logic          accept;
    logic [AW-2:0] req_idx;
    logic [AW-2:0] req_idx_next;
    logic [AW-2:0] ld_idx;
    logic [31:0]   pend_data;
    logic          pend_rvc;

    assign req_idx      = req_addr[AW-1:1];
    assign req_idx_next = req_idx + {{(AW-2){1'b0}}, 1'b1};
    assign ld_idx       = ld_addr[AW-1:1];
    assign accept       = req_valid && req_ready;
    assign dbg_state    = state;

    // Odd windows take their high half from the next even slot; the index
    // increment wraps naturally so the top address pairs with halfword 0.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (ld_addr[0]) begin
                bank1[ld_idx] <= ld_data;
            end else begin
                bank0[ld_idx] <= ld_data;
            end
        end
        if (accept) begin
            rd0 <= bank0[req_addr[0] ? req_idx_next : req_idx];
            rd1 <= bank1[req_idx];
        end
    end

    assign pend_data = odd_q ? {rd0, rd1} : {rd1, rd0};
    assign pend_rvc  = (pend_data[1:0] != 2'b11);

    always_comb begin
        req_ready = 1'b0;
        if (!ld_en) begin
            case (state)
                ST_EMPTY: req_ready = 1'b1;
                ST_PEND:  req_ready = resp_ready;
                ST_HOLD:  req_ready = flush;
                default:  req_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_addr  = '0;
        resp_rvc   = 1'b0;
        case (state)
            ST_PEND: begin
                resp_valid = !flush;
                resp_data  = pend_data;
                resp_addr  = addr_q;
                resp_rvc   = pend_rvc;
            end
            ST_HOLD: begin
                resp_valid = !flush;
                resp_data  = hold_data;
                resp_addr  = hold_addr;
                resp_rvc   = hold_rvc;
            end
            default: ;
        endcase
    end

    // Flush outranks every other transition; a same-cycle accept restarts in PEND.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_EMPTY;
            odd_q     <= 1'b0;
            addr_q    <= '0;
            hold_data <= '0;
            hold_addr <= '0;
            hold_rvc  <= 1'b0;
        end else begin
            if (accept) begin
                odd_q  <= req_addr[0];
                addr_q <= req_addr;
            end
            if (flush) begin
                state <= accept ? ST_PEND : ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: if (accept) state <= ST_PEND;
                    ST_PEND: begin
                        if (resp_ready) begin
                            state <= accept ? ST_PEND : ST_EMPTY;
                        end else begin
                            state     <= ST_HOLD;
                            hold_data <= pend_data;
                            hold_addr <= addr_q;
                            hold_rvc  <= pend_rvc;
                        end
                    end
                    ST_HOLD: if (resp_ready) state <= ST_EMPTY;
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: doc/imemory_fetch.md
# imemory_fetch

Parametrised, halfword-banked instruction memory with a valid/ready fetch port, a stall-hold register, a flush input and a halfword program-load port. It returns a 32-bit fetch window from any halfword-aligned address, including addresses that straddle a word boundary, so compressed and full-width instructions can be fetched at any halfword. It sits between the IF-stage PC logic and the decoder and supports one fetch per cycle when the decoder is not stalling.

## Interface
Parameters:
- AW, 10, halfword address width; total capacity is 2**AW halfwords.
- BANK_DEPTH, 2**(AW-1), entries per 16-bit bank (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  AW  halfword address of the fetch window.
- resp_valid  out  1  resp_data is valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  {halfword[addr+1], halfword[addr]}.
- resp_addr  out  AW  req_addr of the current response.
- resp_rvc  out  1  resp_data[1:0] != 2'b11, meaning the low halfword is a compressed instruction.
- flush  in  1  discards any pending or held response (redirect).
- ld_en  in  1  program-load write strobe.
- ld_addr  in  AW  halfword address to write.
- ld_data  in  16  halfword to write.

## Operation
- **Bank mapping.** Bank0 holds the even halfwords and bank1 holds the odd halfwords, both at index addr>>1. Banks are synchronous-read, synchronous-write 16-bit arrays with no reset. Their contents are undefined until loaded.
- **Even fetch address.** Low half = bank0[a>>1], high half = bank1[a>>1].
- **Odd fetch address.** Low half = bank1[a>>1], high half = bank0[((a>>1)+1) mod BANK_DEPTH]. Address 2**AW-1 therefore wraps, and its high half is halfword 0.
- **Load.** When ld_en=1, the bank selected by ld_addr[0] is written at ld_addr>>1 on the edge. No new read is started that cycle.
- **Fetch states.**
  - EMPTY: nothing outstanding.
  - PEND: read issued last cycle; data comes straight from the bank outputs.
  - HOLD: response captured in the hold register.
- **req_ready** = !ld_en && !flush_block && (state==EMPTY || (state==PEND && resp_ready)).
  - flush_block is always 0. A flush never blocks a request issued in the same cycle.
  - HOLD forces req_ready=0, except when flush is asserted: then req_ready = !ld_en.
- **Transitions.**
  - EMPTY → PEND on accept.
  - PEND → PEND on accept with resp_ready.
  - PEND → EMPTY on resp_ready with no accept.
  - PEND → HOLD on !resp_ready; the hold register captures data, address and rvc.
  - HOLD → EMPTY on resp_ready.
- **Flush (highest priority).**
  - The current response is dropped and resp_valid goes to 0 in the same cycle (resp_valid is gated by !flush).
  - Next state is PEND if a request is accepted in the same cycle, else EMPTY.
- **Load during PEND/HOLD.** A load does not disturb the pending bank outputs or the hold register. Writing the address being fetched changes only later fetches.
- **Reset.** State goes to EMPTY and the hold register clears to 0.

## Timing
- **Reset values.** req_ready=1 (if ld_en=0), resp_valid=0, resp_data=0, resp_addr=0, resp_rvc=0.
- **Latency.** A request accepted in cycle N appears with resp_valid=1 in cycle N+1.
- **Throughput.** One response per cycle while resp_ready=1 and ld_en=0.
- **Stall.** If resp_ready=0 in cycle N+1, the response from N+2 onward comes from the hold register and stays bit-stable until accepted. No request is accepted while in HOLD.
- **Output muxing.** resp_data, resp_addr and resp_rvc are muxed from the bank outputs in PEND and from the hold register in HOLD. In EMPTY they are 0.
- **Selection registers.** The odd/even select and resp_addr come from the address registered at accept.
- **Simultaneous load and fetch request.** The load wins and the request waits (req_ready=0).
- **Reset mid-stall.** Asynchronous: outputs reach their reset values immediately, and the held data is lost.

## Test plan
- **Even fetch.** Load halfword i = 0x1000+i for i=0..7, then fetch addr 0 → resp_valid in the next cycle, resp_data=0x1001_1000, resp_rvc=1.
- **Odd fetch.** Fetch addr 3 → 0x1004_1003. Load hw5=0x0013, hw6=0x0000, then fetch addr 5 → 0x0000_0013, resp_rvc=0.
- **Wrap.** AW=10, hw0x3FF=0xBEEF, hw0=0x1234. Fetch 0x3FF → 0x1234_BEEF, resp_addr=0x3FF.
- **Back-to-back with stall.**
  - Back-to-back fetches of 0, 2, 4 with resp_ready=1 → responses on three consecutive cycles.
  - Drop resp_ready while addr 2 is presented for 3 cycles → data held stable and req_ready=0.
  - On release → addr 4 follows, no loss or duplicate.
- **Flush in HOLD with a same-cycle request.** Flush in HOLD while requesting addr 6 → resp_valid=0 that cycle, next cycle resp_data=0x1007_1006, and the stale response is never accepted.
- **Load collision and reset.** ld_en together with req_valid → req_ready=0 and the write lands. Later, assert resetn=0 during HOLD → resp_valid=0 and resp_data=0 without a clock edge.
